// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Expected parity bit for the data word: even makes the total ones count even.
  function automatic logic parity_calc(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Received-byte handshake between the UART receiver and its on-chip consumer.
interface uart_rx_oversample_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output data, data_valid, frame_err, parity_err, overrun,
    input  data_ready
  );

  modport slave (
    input  data, data_valid, frame_err, parity_err, overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for the serial pin plus a 3-tap majority vote over
// the current and two previous synchronised samples.
module uart_bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_async,
  output logic rx_s,
  output logic maj
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] hist_q, hist_d;

  always_comb begin
    sync1_d = rx_async;
    sync2_d = sync1_q;
    hist_d  = {hist_q[0], sync2_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 2'b11;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign rx_s = sync2_q;
  // Vote includes the live sample so the decision lands on the third tap.
  assign maj  = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: start detect, mid-cell majority sampling,
// optional parity, and a one-deep output holding register with overrun flag.
//
// state  | meaning
// IDLE   | waiting for a falling edge on rx_s (only after a 1 has been seen)
// START  | validating the start bit; a high majority is treated as a glitch
// DATA   | sampling DATA_BITS data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit; result issued at mid-cell
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_rx,
  input  logic                 u_rx,
  uart_rx_oversample_if.master rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(CLKS_PER_BIT / 2 + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_s;
  logic maj;

  uart_bit_sync u_bit_sync (
    .clk      (clk),
    .rst      (rst),
    .rx_async (u_rx),
    .rx_s     (rx_s),
    .maj      (maj)
  );

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ovr_q, ovr_d;

  logic       cnt_wrap;
  logic       decide;
  logic       done;
  logic       accept;
  logic [7:0] par_in;

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    armed_d  = 1'b0;
    done     = 1'b0;
    par_in   = '0;
    par_in[DATA_BITS-1:0] = shift_q;

    cnt_wrap = (cnt_q == CNT_MAX);
    decide   = (cnt_q == CNT_DEC);
    cnt_d    = (state_q == IDLE || cnt_wrap) ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        // A line held low after a frame must go high before a new start counts.
        armed_d = rx_s;
        if (en_rx && armed_q && !rx_s) begin
          state_d = START;
          bit_d   = '0;
          perr_d  = 1'b0;
        end
      end
      START: begin
        if (decide && maj) state_d = IDLE;
        else if (cnt_wrap) state_d = DATA;
      end
      DATA: begin
        if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (cnt_wrap) begin
          if (bit_q == BIT_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      PARITY: begin
        if (decide) perr_d = maj ^ parity_calc(par_in, PARITY_ODD != 0);
        if (cnt_wrap) state_d = STOP;
      end
      STOP: begin
        if (decide) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept     = valid_q & rx_if.data_ready;
    data_d     = data_q;
    valid_d    = valid_q;
    ferr_d     = ferr_q;
    perr_out_d = perr_out_q;
    ovr_d      = 1'b0;

    if (accept) valid_d = 1'b0;
    // A same-cycle accept frees the holding register for the new byte.
    if (done) begin
      if (!valid_q || accept) begin
        data_d     = shift_q;
        ferr_d     = ~maj;
        perr_out_d = perr_q;
        valid_d    = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      armed_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_if.data       = data_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.parity_err = perr_out_q;
  assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench: one receiver without parity, one with even parity.
module tb_uart_rx_oversample;

  localparam int CPB = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_rx = 1'b1;
  logic line = 1'b1;
  logic sel = 1'b0;
  logic ready0 = 1'b1;
  logic ready1 = 1'b1;
  logic u_rx0, u_rx1;

  int n_chk = 0;
  int n_err = 0;
  int acc0 = 0, acc1 = 0, ovr0 = 0, ovr1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  assign u_rx0 = sel ? 1'b1 : line;
  assign u_rx1 = sel ? line : 1'b1;

  uart_rx_oversample_if #(.DATA_BITS(8)) if0 ();
  uart_rx_oversample_if #(.DATA_BITS(8)) if1 ();
  assign if0.data_ready = ready0;
  assign if1.data_ready = ready1;

  uart_rx_oversample #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .en_rx(en_rx), .u_rx(u_rx0), .rx_if(if0.master)
  );

  uart_rx_oversample #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .en_rx(en_rx), .u_rx(u_rx1), .rx_if(if1.master)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if0.overrun) ovr0++;
    if (if1.overrun) ovr1++;
    if (if0.data_valid && if0.data_ready) begin
      acc0++;
      if (q0.size() == 0) chk_eq("dut0_spurious_byte", 32'(q0.size()), 1);
      else begin
        e0 = q0.pop_front();
        chk_eq("dut0_data", 32'(if0.data), 32'(e0.d));
        chk_eq("dut0_frame_err", 32'(if0.frame_err), 32'(e0.fe));
        chk_eq("dut0_parity_err", 32'(if0.parity_err), 32'(e0.pe));
      end
    end
    if (if1.data_valid && if1.data_ready) begin
      acc1++;
      if (q1.size() == 0) chk_eq("dut1_spurious_byte", 32'(q1.size()), 1);
      else begin
        e1 = q1.pop_front();
        chk_eq("dut1_data", 32'(if1.data), 32'(e1.d));
        chk_eq("dut1_frame_err", 32'(if1.frame_err), 32'(e1.fe));
        chk_eq("dut1_parity_err", 32'(if1.parity_err), 32'(e1.pe));
      end
    end
  end

  task automatic idle_bits(input int n);
    line = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  // drop_at / rst_at: bit-cell index (0 = start) at which en_rx falls or rst pulses.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit,
                            input int drop_at, input int rst_at);
    logic [10:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (sel) begin
      bits[9] = pbit;
      bits[10] = stop;
      nb = 11;
    end else begin
      bits[9] = stop;
      nb = 10;
    end
    for (int i = 0; i < nb; i++) begin
      if (i == drop_at) en_rx = 1'b0;
      line = bits[i];
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (CPB - 1) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
    end
    chk_eq(tag, 32'(q0.size() + q1.size()), 0);
  endtask

  initial begin
    int a0;
    int o0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_eq("rst_data", 32'(if0.data), 0);
    chk_eq("rst_valid", 32'(if0.data_valid), 0);
    chk_eq("rst_frame_err", 32'(if0.frame_err), 0);
    chk_eq("rst_parity_err", 32'(if0.parity_err), 0);
    chk_eq("rst_overrun", 32'(if0.overrun), 0);
    idle_bits(1);

    q0.push_back('{d: 8'h95, fe: 1'b0, pe: 1'b0});
    send_frame(8'h95, 1'b1, 1'b0, -1, -1);
    idle_bits(2);
    wait_drain("drain_95");

    a0 = acc0;
    line = 1'b0;
    @(negedge clk);
    line = 1'b1;
    idle_bits(3);
    chk_eq("glitch_no_valid", 32'(acc0 - a0), 0);

    // Stop bit low followed by a break: one framing-error byte, no restart.
    q0.push_back('{d: 8'hA5, fe: 1'b1, pe: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b0, -1, -1);
    line = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    idle_bits(2);
    wait_drain("drain_a5_break");

    q0.push_back('{d: 8'h00, fe: 1'b0, pe: 1'b0});
    q0.push_back('{d: 8'hFF, fe: 1'b0, pe: 1'b0});
    send_frame(8'h00, 1'b1, 1'b0, -1, -1);
    send_frame(8'hFF, 1'b1, 1'b0, -1, -1);
    idle_bits(2);
    wait_drain("drain_back_to_back");

    sel = 1'b1;
    q1.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b1});
    send_frame(8'h07, 1'b1, 1'b0, -1, -1);
    idle_bits(1);
    q1.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b0});
    send_frame(8'h07, 1'b1, 1'b1, -1, -1);
    idle_bits(1);
    q1.push_back('{d: 8'h95, fe: 1'b0, pe: 1'b0});
    send_frame(8'h95, 1'b1, 1'b0, -1, -1);
    idle_bits(2);
    wait_drain("drain_parity");
    sel = 1'b0;

    ready0 = 1'b0;
    o0 = ovr0;
    q0.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
    send_frame(8'h11, 1'b1, 1'b0, -1, -1);
    idle_bits(1);
    send_frame(8'h22, 1'b1, 1'b0, -1, -1);
    idle_bits(1);
    chk_eq("overrun_pulses", 32'(ovr0 - o0), 1);
    chk_eq("overrun_data_kept", 32'(if0.data), 32'h11);
    chk_eq("overrun_valid_held", 32'(if0.data_valid), 1);
    ready0 = 1'b1;
    wait_drain("drain_overrun");
    repeat (2) @(negedge clk);
    chk_eq("valid_clear_after_accept", 32'(if0.data_valid), 0);

    a0 = acc0;
    send_frame(8'hFF, 1'b1, 1'b0, -1, 5);
    idle_bits(2);
    chk_eq("rst_midframe_no_output", 32'(acc0 - a0), 0);
    q0.push_back('{d: 8'h3C, fe: 1'b0, pe: 1'b0});
    send_frame(8'h3C, 1'b1, 1'b0, -1, -1);
    idle_bits(2);
    wait_drain("drain_3c");
    chk_eq("rst_then_3c_count", 32'(acc0 - a0), 1);

    en_rx = 1'b0;
    a0 = acc0;
    send_frame(8'h5A, 1'b1, 1'b0, -1, -1);
    idle_bits(2);
    chk_eq("en_low_ignored", 32'(acc0 - a0), 0);
    en_rx = 1'b1;
    q0.push_back('{d: 8'h6B, fe: 1'b0, pe: 1'b0});
    send_frame(8'h6B, 1'b1, 1'b0, 3, -1);
    idle_bits(2);
    wait_drain("drain_en_drop");
    a0 = acc0;
    send_frame(8'h12, 1'b1, 1'b0, -1, -1);
    idle_bits(2);
    chk_eq("en_dropped_ignores_next", 32'(acc0 - a0), 0);
    en_rx = 1'b1;

    chk_eq("dut1_no_overrun", 32'(ovr1), 0);
    chk_eq("dut1_byte_count", 32'(acc1), 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
